// File: rtl/femtosoc_bus_arbiter_if.sv
// Native PicoRV32 memory-bus bundle for the two-master arbiter.
// The arbiter uses the slave modport; the requester/RAM side uses master.
`timescale 1ns/1ps
interface femtosoc_bus_arbiter_if;
   logic        m0_valid;
   logic [3:0]  m0_wstrb;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_ready;
   logic [31:0] m0_rdata;

   logic        m1_valid;
   logic [3:0]  m1_wstrb;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_ready;
   logic [31:0] m1_rdata;

   logic        s_valid;
   logic [3:0]  s_wstrb;
   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic        s_ready;
   logic [31:0] s_rdata;

   modport slave (
      input  m0_valid, m0_wstrb, m0_addr, m0_wdata,
      output m0_ready, m0_rdata,
      input  m1_valid, m1_wstrb, m1_addr, m1_wdata,
      output m1_ready, m1_rdata,
      output s_valid, s_wstrb, s_addr, s_wdata,
      input  s_ready, s_rdata
   );

   modport master (
      output m0_valid, m0_wstrb, m0_addr, m0_wdata,
      input  m0_ready, m0_rdata,
      output m1_valid, m1_wstrb, m1_addr, m1_wdata,
      input  m1_ready, m1_rdata,
      input  s_valid, s_wstrb, s_addr, s_wdata,
      output s_ready, s_rdata
   );
endinterface

// File: rtl/femtosoc_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32 native bus, with a watchdog
// that completes a stalled transfer with ERR_DATA so a dead slave cannot hang the SoC.
`timescale 1ns/1ps
module femtosoc_bus_arbiter #(
   parameter int          TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic       clk,
   input  logic       reset,
   femtosoc_bus_arbiter_if.slave bus,
   output logic       busy,
   output logic       timeout_err,
   output logic [7:0] err_count
);

   localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST =
      WDOG_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t            state;
   logic              last_grant;
   logic [WDOG_W-1:0] wdog;

   logic        gnt0;
   logic        gnt1;
   logic        gnt_valid;
   logic        done_ok;
   logic        expire;
   logic        done;
   logic [31:0] resp_data;

   assign gnt0      = (state == GRANT0);
   assign gnt1      = (state == GRANT1);
   assign gnt_valid = (gnt0 & bus.m0_valid) | (gnt1 & bus.m1_valid);
   assign done_ok   = gnt_valid & bus.s_ready;
   // s_ready in the expiry cycle wins, so expiry requires no s_ready.
   assign expire    = (TIMEOUT_CYCLES != 0) && gnt_valid && !bus.s_ready && (wdog == WDOG_LAST);
   assign done      = done_ok | expire;
   assign resp_data = expire ? ERR_DATA : bus.s_rdata;

   always_comb begin
      bus.s_valid  = gnt_valid;
      bus.s_wstrb  = 4'h0;
      bus.s_addr   = 32'h0;
      bus.s_wdata  = 32'h0;
      if (gnt0) begin
         bus.s_wstrb = bus.m0_wstrb;
         bus.s_addr  = bus.m0_addr;
         bus.s_wdata = bus.m0_wdata;
      end else if (gnt1) begin
         bus.s_wstrb = bus.m1_wstrb;
         bus.s_addr  = bus.m1_addr;
         bus.s_wdata = bus.m1_wdata;
      end
   end

   // Completion is combinational on s_ready so the master sees ready in the slave's cycle.
   always_comb begin
      bus.m0_ready = gnt0 & done;
      bus.m1_ready = gnt1 & done;
      bus.m0_rdata = (gnt0 & done) ? resp_data : 32'h0;
      bus.m1_rdata = (gnt1 & done) ? resp_data : 32'h0;
      timeout_err  = expire;
      busy         = (state != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         wdog       <= '0;
         err_count  <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               wdog <= '0;
               // On a tie the master that did not win the previous tie is served.
               if (bus.m0_valid && (!bus.m1_valid || last_grant)) begin
                  state <= GRANT0;
                  if (bus.m1_valid) last_grant <= 1'b0;
               end else if (bus.m1_valid) begin
                  state <= GRANT1;
                  if (bus.m0_valid) last_grant <= 1'b1;
               end
            end
            GRANT0, GRANT1: begin
               if (!gnt_valid || done) state <= IDLE;
               else                    wdog  <= wdog + 1'b1;
               if (expire && (err_count != 8'hFF)) err_count <= err_count + 8'h01;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_femtosoc_bus_arbiter.sv
// Scoreboard bench for femtosoc_bus_arbiter: directed transfers, ties, timeouts,
// saturation of the error counter and asynchronous reset mid-transfer.
`timescale 1ns/1ps
module tb_femtosoc_bus_arbiter;
   localparam int          TMO = 8;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic       clk;
   logic       reset;
   logic       busy;
   logic       timeout_err;
   logic [7:0] err_count;

   femtosoc_bus_arbiter_if bus ();

   femtosoc_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_count   (err_count)
   );

   typedef struct {
      int          m;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   int          errs  = 0;
   int          slave_delay = -1;
   logic [31:0] slave_data  = 32'h0;
   int          scnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Slave: ready when it has seen s_valid for slave_delay+1 cycles; negative = never.
   always @(posedge clk) begin
      #2;
      bus.s_rdata = slave_data;
      if (bus.s_valid === 1'b1) begin
         bus.s_ready = (scnt == slave_delay);
         scnt++;
      end else begin
         bus.s_ready = 1'b0;
         scnt = 0;
      end
   end

   // Monitor pops the scoreboard on every completion.
   always @(negedge clk) begin
      exp_t e;
      if (bus.m0_ready === 1'b1 || bus.m1_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk_eq("sb_empty", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk_eq("who", {30'd0, bus.m1_ready, bus.m0_ready}, (e.m == 1) ? 32'd2 : 32'd1);
            chk_eq("rdata", (e.m == 1) ? bus.m1_rdata : bus.m0_rdata, e.rdata);
            chk_eq("other_rdata", (e.m == 1) ? bus.m0_rdata : bus.m1_rdata, 32'h0);
            chk_eq("terr", {31'd0, timeout_err}, {31'd0, e.err});
         end
      end else if (timeout_err !== 1'b0) begin
         chk_eq("terr_stray", {31'd0, timeout_err}, 32'd0);
      end
   end

   task automatic push(input int m, input logic [31:0] rdata, input logic err);
      exp_t e;
      e.m = m; e.rdata = rdata; e.err = err;
      sb.push_back(e);
   endtask

   task automatic set_m(input int m, input logic v, input logic [31:0] addr,
                        input logic [3:0] wstrb, input logic [31:0] wdata);
      if (m == 0) begin
         bus.m0_valid = v; bus.m0_addr = addr; bus.m0_wstrb = wstrb; bus.m0_wdata = wdata;
      end else begin
         bus.m1_valid = v; bus.m1_addr = addr; bus.m1_wstrb = wstrb; bus.m1_wdata = wdata;
      end
   endtask

   task automatic run_one(input int m, input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input int delay, input logic [31:0] rdata);
      logic exp_err;
      int   k;
      bit   got;
      exp_err = (delay < 0) || (delay >= TMO);
      slave_delay = delay;
      slave_data  = rdata;
      push(m, exp_err ? ERR : rdata, exp_err);
      if (exp_err && errs < 255) errs++;
      @(posedge clk); #1;
      set_m(m, 1'b1, addr, wstrb, wdata);
      k = 0; got = 0;
      while (!got && k < 40) begin
         @(negedge clk);
         k++;
         if (k == 1) chk_eq("sv_idle", {31'd0, bus.s_valid}, 32'd0);
         if (k == 2) begin
            chk_eq("sv_grant", {31'd0, bus.s_valid}, 32'd1);
            chk_eq("s_addr", bus.s_addr, addr);
            chk_eq("s_wstrb", {28'd0, bus.s_wstrb}, {28'd0, wstrb});
            chk_eq("s_wdata", bus.s_wdata, wdata);
         end
         got = (m == 0) ? (bus.m0_ready === 1'b1) : (bus.m1_ready === 1'b1);
      end
      chk_eq("latency", k, exp_err ? TMO + 1 : delay + 2);
      @(posedge clk); #1;
      set_m(m, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      chk_eq("busy_after", {31'd0, busy}, 32'd0);
      chk_eq("err_count", {24'd0, err_count}, errs);
   endtask

   // Both masters held; expects n completions alternating from m0, one IDLE cycle apart.
   task automatic run_tie(input int n);
      int k;
      int seen;
      slave_delay = 1;
      for (int i = 0; i < n; i++) push(i % 2, 32'hA000_0000 + i, 1'b0);
      @(posedge clk); #1;
      set_m(0, 1'b1, 32'h100, 4'h0, 32'h0);
      set_m(1, 1'b1, 32'h200, 4'h0, 32'h0);
      k = 0; seen = 0;
      slave_data = 32'hA000_0000;
      while (seen < n && k < 20 * n) begin
         @(negedge clk);
         k++;
         if (bus.m0_ready === 1'b1 || bus.m1_ready === 1'b1) begin
            seen++;
            chk_eq("tie_gap", k, 3 * seen);
            slave_data = 32'hA000_0000 + seen;
         end
      end
      chk_eq("tie_count", seen, n);
      @(posedge clk); #1;
      set_m(0, 1'b0, 32'h0, 4'h0, 32'h0);
      set_m(1, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      errs = 0;
   endtask

   initial begin
      reset = 1'b1;
      set_m(0, 1'b0, 32'h0, 4'h0, 32'h0);
      set_m(1, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_eq("rst_busy", {31'd0, busy}, 32'd0);
      chk_eq("rst_svalid", {31'd0, bus.s_valid}, 32'd0);
      chk_eq("rst_ready", {30'd0, bus.m1_ready, bus.m0_ready}, 32'd0);
      chk_eq("rst_errcnt", {24'd0, err_count}, 32'd0);
      chk_eq("rst_terr", {31'd0, timeout_err}, 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      // T1: basic read, plus a zero-wait and a longer-wait transfer
      run_one(0, 32'h0000_0010, 4'h0, 32'h0, 1, 32'h1234_5678);
      run_one(1, 32'h0000_0400, 4'h0, 32'h0, 0, 32'h0BAD_F00D);
      run_one(1, 32'h0000_0800, 4'h1, 32'h0000_00EE, 3, 32'h4444_3333);

      // T2: simultaneous requests from reset alternate m0, m1, m0, m1
      pulse_reset();
      run_tie(4);

      // T3: write to a dead slave times out after TMO grant cycles
      run_one(1, 32'h0300_0000, 4'hF, 32'hCAFE_0001, -1, 32'h5555_0000);

      // T4: ready in the final wait cycle beats the watchdog
      run_one(0, 32'h0000_2000, 4'h3, 32'h0000_A5A5, TMO - 1, 32'h7777_0000);

      // Master abandons its request before ready
      slave_delay = -1;
      @(posedge clk); #1;
      set_m(1, 1'b1, 32'h0000_3000, 4'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1 set_m(1, 1'b0, 32'h0, 4'h0, 32'h0);
      #1 chk_eq("drop_svalid", {31'd0, bus.s_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk_eq("drop_busy", {31'd0, busy}, 32'd0);
      chk_eq("drop_errcnt", {24'd0, err_count}, errs);

      // T5: error counter saturates
      for (int i = 0; i < 300; i++)
         run_one(i % 2, 32'h0300_0000 + 4 * i, 4'h0, 32'h0, -1, 32'h0);
      chk_eq("sat", {24'd0, err_count}, 32'd255);

      // T6: asynchronous reset while GRANT0 waits
      slave_delay = -1;
      @(posedge clk); #1;
      set_m(0, 1'b1, 32'h0000_0040, 4'h0, 32'h0);
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk_eq("arst_svalid", {31'd0, bus.s_valid}, 32'd0);
      chk_eq("arst_busy", {31'd0, busy}, 32'd0);
      chk_eq("arst_ready", {31'd0, bus.m0_ready}, 32'd0);
      set_m(0, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      errs = 0;
      @(negedge clk);
      chk_eq("arst_errcnt", {24'd0, err_count}, 32'd0);
      chk_eq("sb_drained", sb.size(), 32'd0);
      run_tie(2);
      chk_eq("sb_final", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
